// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter: three requesters share one register bank write port.
// Two-state FSM with registered outputs; each grant is a one-cycle write pulse.
module reg_wr_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int ZERO_R0 = 1,
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [2:0]       req,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [2:0]       gnt,
    output logic [NREG-1:0]  wr_sel,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic [7:0]       wr_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [NREG-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             found;
    logic [1:0]       win;
    logic [2:0]       idx;
    logic [AW-1:0]    win_addr;
    logic [WIDTH-1:0] win_data;
    logic [NREG-1:0]  dec;

    // Scan ptr, ptr+1, ptr+2 (mod 3); the first active request wins.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!found && req[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
    end

    always_comb begin
        case (win)
            2'd1:    begin win_addr = addr1; win_data = data1; end
            2'd2:    begin win_addr = addr2; win_data = data2; end
            default: begin win_addr = addr0; win_data = data0; end
        endcase
    end

    // Out-of-range addresses and a hardwired register 0 decode to no select.
    always_comb begin
        dec = '0;
        for (int k = 0; k < NREG; k++) begin
            if (win_addr == AW'(k) && !(ZERO_R0 != 0 && k == 0))
                dec[k] = 1'b1;
        end
    end

    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        sel_d   = '0;
        data_d  = '0;
        busy_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == IDLE && !flush && found) begin
            state_d = GRANT;
            ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
            gnt_d   = 3'b001 << win;
            sel_d   = dec;
            data_d  = win_data;
            busy_d  = 1'b1;
            if (dec != '0 && cnt_q != 8'hFF)
                cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_sel  = sel_q;
    assign wr_data = data_q;
    assign busy    = busy_q;
    assign wr_cnt  = cnt_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: a round-robin reference model queues
// the expected write per grant; a negedge monitor compares DUT outputs.
module tb_reg_wr_arbiter;

    localparam int WIDTH = 16;
    localparam int NREG  = 8;
    localparam int AW    = 3;
    localparam int ZERO  = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [2:0]       req = '0;
    logic [AW-1:0]    addr [3];
    logic [WIDTH-1:0] data [3];
    logic [2:0]       gnt;
    logic [NREG-1:0]  wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic [7:0]       wr_cnt;

    typedef struct packed {
        logic [2:0]       g;
        logic [NREG-1:0]  s;
        logic [WIDTH-1:0] d;
        logic [7:0]       c;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   m_grants = 0;
    bit   m_busy = 1'b0;
    bit   keep [3];

    reg_wr_arbiter #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_R0(ZERO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req(req),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]),
        .data0(data[0]), .data1(data[1]), .data2(data[2]),
        .gnt(gnt), .wr_sel(wr_sel), .wr_data(wr_data),
        .busy(busy), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (gnt != 3'b000) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt=%b expected none", gnt);
                end else begin
                    e = expq.pop_front();
                    chk("gnt", 32'(gnt), 32'(e.g));
                    chk("wr_sel", 32'(wr_sel), 32'(e.s));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                    chk("wr_cnt", 32'(wr_cnt), 32'(e.c));
                    chk("busy", 32'(busy), 32'd1);
                end
            end else begin
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_grant: got gnt=000 expected %b", e.g);
                end
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_sel", 32'(wr_sel), 32'd0);
                chk("idle_data", 32'(wr_data), 32'd0);
            end
        end
    end

    // Reference model: one clock edge as seen by the arbiter's rules.
    task automatic tick();
        exp_t            e;
        int              w;
        int              a;
        logic [NREG-1:0] sel;
        w = -1;
        @(posedge clk);
        if (m_busy) begin
            m_busy = 1'b0;
        end else if (!flush && req != 3'b000) begin
            for (int k = 0; k < 3; k++)
                if (w < 0 && req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
            a   = int'(addr[w]);
            sel = '0;
            if (!((ZERO != 0 && a == 0) || a >= NREG)) sel = NREG'(1) << a;
            if (sel != '0 && m_cnt < 255) m_cnt++;
            e.g = 3'(1 << w);
            e.s = sel;
            e.d = data[w];
            e.c = 8'(m_cnt);
            expq.push_back(e);
            m_ptr = (w + 1) % 3;
            m_busy = 1'b1;
            m_grants++;
        end
        #1;
        if (w >= 0) begin
            req[w] = keep[w];
            if (keep[w]) data[w] = WIDTH'($urandom);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(wr_sel), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(wr_cnt), 32'd0);
        expq.delete();
        m_ptr = 0;
        m_cnt = 0;
        m_busy = 1'b0;
        req = '0;
        flush = 1'b0;
        keep = '{default: 1'b0};
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int start;
        addr = '{default: '0};
        data = '{default: '0};
        keep = '{default: 1'b0};
        do_reset();

        addr[1] = 3'd5;
        data[1] = 16'hBEEF;
        req = 3'b010;
        repeat (3) tick();
        chk("single_cnt", 32'(wr_cnt), 32'd1);

        do_reset();
        addr[0] = 3'd1; addr[1] = 3'd2; addr[2] = 3'd3;
        data[0] = 16'h1111; data[1] = 16'h2222; data[2] = 16'h3333;
        req = 3'b111;
        repeat (7) tick();
        chk("contention_cnt", 32'(wr_cnt), 32'd3);

        keep[0] = 1'b1;
        keep[2] = 1'b1;
        addr[0] = 3'd1;
        addr[2] = 3'd2;
        req = 3'b101;
        repeat (10) tick();
        keep = '{default: 1'b0};
        req = '0;
        repeat (2) tick();

        addr[0] = 3'd0;
        data[0] = 16'hA5A5;
        req = 3'b001;
        repeat (3) tick();

        flush = 1'b1;
        addr[2] = 3'd4;
        data[2] = 16'h4444;
        req = 3'b100;
        repeat (2) tick();
        flush = 1'b0;
        repeat (2) tick();

        addr[0] = 3'd6;
        data[0] = 16'h6666;
        req = 3'b001;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        addr[1] = 3'd7;
        data[1] = 16'h7777;
        req = 3'b010;
        tick();
        do_reset();

        keep[0] = 1'b1;
        addr[0] = 3'd3;
        req = 3'b001;
        start = m_grants;
        for (int i = 0; i < 800 && m_grants - start < 300; i++) tick();
        keep = '{default: 1'b0};
        req = '0;
        repeat (2) tick();
        chk("sat_cnt", 32'(wr_cnt), 32'd255);

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    addr[i] = AW'($urandom_range(0, 7));
                    data[i] = WIDTH'($urandom);
                    req[i] = 1'b1;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        req = '0;
        flush = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of the shared register bank write port.
REQ-002 Parameter NREG, default 8, number of registers in the bank; address width is log2(NREG), 3 at default.
REQ-003 Parameter ZERO_R0, default 1, when 1 register 0 is never written.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous cancel of pending arbitration.
REQ-007 req  input  3  per-requester write request, bit i = requester i.
REQ-008 addr0, addr1, addr2  input  log2(NREG) each  target register of requester i.
REQ-009 data0, data1, data2  input  WIDTH each  write data of requester i.
REQ-010 gnt  output  3  one-hot grant pulse to requester i.
REQ-011 wr_sel  output  NREG  one-hot write enable, bit k drives the wr input of register k.
REQ-012 wr_data  output  WIDTH  data driven to the in port of every register in the bank.
REQ-013 busy  output  1  high while in GRANT state.
REQ-014 wr_cnt  output  8  count of committed writes, saturating.

Function
REQ-015 Two-state FSM: IDLE and GRANT; all outputs registered, no combinational input-to-output path.
REQ-016 IDLE, flush=0, req!=0 at edge: select winner w by round-robin, capture addrw/dataw, next state GRANT.
REQ-017 IDLE, req=0 or flush=1 at edge: remain IDLE; no capture; pointer unchanged.
REQ-018 GRANT lasts exactly one cycle; gnt[w]=1, wr_data=captured data, wr_sel=one-hot(captured addr), busy=1; next state IDLE unconditionally.
REQ-019 All outputs other than wr_cnt are 0 in IDLE; gnt, wr_sel, busy are single-cycle pulses.
REQ-020 Latency: req sampled at edge N -> gnt/wr_sel visible in cycle N+1 -> register bank captures wr_data at edge N+2.
REQ-021 Throughput: at most one write per two cycles; a requester seeing gnt updates req/addr/data at the end of the GRANT cycle and cannot be double-granted.
REQ-022 Requester SHALL hold req, addr, data stable from assertion until the cycle its gnt bit is high; arbiter does not check this.
REQ-023 Round-robin pointer ptr in 0..2: priority order ptr, ptr+1, ptr+2 mod 3; after grant to w, ptr=(w+1) mod 3.
REQ-024 Simultaneous requests: only the highest-priority requester granted; others remain pending, no loss.
REQ-025 ZERO_R0=1 and captured addr=0: gnt pulse still issued, wr_sel=0, wr_cnt not incremented.
REQ-026 wr_cnt increments by 1 on every GRANT cycle with wr_sel!=0; holds at 255 (no wrap).
REQ-027 flush asserted in GRANT cycle: that write completes normally; flush only affects IDLE sampling.
REQ-028 Address >= NREG (non-power-of-2 NREG): gnt issued, wr_sel=0, wr_cnt unchanged.

Reset
REQ-029 rst=0 forces immediately, independent of clk: state IDLE, ptr=0, gnt=0, wr_sel=0, wr_data=0, busy=0, wr_cnt=0.
REQ-030 rst asserted during GRANT aborts the write: wr_sel drops to 0 asynchronously, captured request discarded.
REQ-031 First arbitration after rst deassertion uses priority order 0,1,2.

Verification
REQ-032 Single request: req=3'b010, addr1=5, data1=16'hBEEF -> one cycle later gnt=3'b010, wr_sel=8'b0010_0000, wr_data=16'hBEEF, wr_cnt=1.
REQ-033 Contention: req=3'b111 held, each requester dropping req after its gnt -> grants in order 0,1,2 on cycles 1,3,5; wr_cnt=3.
REQ-034 Fairness: req=3'b101 held continuously -> grants alternate 0,2,0,2; requester 0 never granted twice in a row.
REQ-035 R0 suppression: req=3'b001, addr0=0, ZERO_R0=1 -> gnt=3'b001, wr_sel=0, wr_cnt unchanged.
REQ-036 Flush/reset: flush=1 with req=3'b100 -> no grant that edge, grant next edge after flush drops; rst=0 mid-GRANT -> wr_sel and gnt 0 immediately, wr_cnt=0.
REQ-037 Saturation: 300 back-to-back single-requester writes to addr 3 -> wr_cnt stops at 255.
